l2_port_scheduler: RTL

//  Shares the single L2 line port between the icache miss port, the dcache miss port
//  (downstream of the eviction write buffer) and a next-line instruction prefetcher.
//  - Dcache has priority; a starvation counter bounds icache wait.
//  - Exactly one transaction is outstanding at a time.

---
 rtl/l2_port_scheduler.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/l2_port_scheduler.sv
// Shares one L2 line port between icache misses, dcache misses and a next-line prefetcher.
// One transaction is outstanding at a time; dcache wins unless the icache has been starved.
module l2_port_scheduler #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int PF_STRIDE  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prefetch_en,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic              i_pmem_resp,
  output logic [LINE_W-1:0] i_pmem_rdata,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic              d_pmem_resp,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              ab_pmem_read,
  output logic              ab_pmem_write,
  output logic [ADDR_W-1:0] ab_pmem_address,
  output logic [LINE_W-1:0] ab_pmem_wdata,
  input  logic              ab_pmem_resp,
  input  logic [LINE_W-1:0] ab_pmem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(5'h1f);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GNT_D = 3'd1,
    GNT_I = 3'd2,
    GNT_P = 3'd3,
    DONE  = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              pf_valid_q, pf_valid_d;
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic              ab_read_q, ab_read_d;
  logic              ab_write_q, ab_write_d;
  logic [ADDR_W-1:0] ab_addr_q, ab_addr_d;
  logic [LINE_W-1:0] ab_wdata_q, ab_wdata_d;

  logic d_req, i_req, starved, pf_hit, granted;

  assign d_req   = d_pmem_read | d_pmem_write;
  assign i_req   = i_pmem_read;
  assign starved = (starve_cnt_q >= CNT_MAX);
  assign pf_hit  = i_req & pf_valid_q &
                   (i_pmem_address[ADDR_W-1:5] == pf_addr_q[ADDR_W-1:5]);
  assign granted = (state_q == GNT_D) | (state_q == GNT_I) | (state_q == GNT_P);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && !starved) begin
          state_d = GNT_D;
        end else if (i_req) begin
          state_d = GNT_I;
        end else if (d_req) begin
          state_d = GNT_D;
        end else if (pf_valid_q && prefetch_en) begin
          state_d = GNT_P;
        end else begin
          state_d = IDLE;
        end
      end
      GNT_D, GNT_I, GNT_P: begin
        if (ab_pmem_resp) begin
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request registers are loaded on the grant edge and held until the L2 responds.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    pf_valid_d   = pf_valid_q;
    pf_addr_d    = pf_addr_q;
    ab_read_d    = ab_read_q;
    ab_write_d   = ab_write_q;
    ab_addr_d    = ab_addr_q;
    ab_wdata_d   = ab_wdata_q;
    if (state_q == IDLE) begin
      if (pf_hit) begin
        pf_valid_d = 1'b0;
      end else begin
        pf_valid_d = pf_valid_q;
      end
      case (state_d)
        GNT_D: begin
          ab_addr_d  = d_pmem_address & LINE_MASK;
          ab_write_d = d_pmem_write;
          ab_read_d  = ~d_pmem_write;
          if (d_pmem_write) begin
            ab_wdata_d = d_pmem_wdata;
          end else begin
            ab_wdata_d = ab_wdata_q;
          end
          if (!i_req) begin
            starve_cnt_d = '0;
          end else if (starve_cnt_q < CNT_MAX) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
          end else begin
            starve_cnt_d = starve_cnt_q;
          end
        end
        GNT_I: begin
          ab_addr_d    = i_pmem_address & LINE_MASK;
          ab_read_d    = 1'b1;
          ab_write_d   = 1'b0;
          starve_cnt_d = '0;
        end
        GNT_P: begin
          ab_addr_d  = pf_addr_q;
          ab_read_d  = 1'b1;
          ab_write_d = 1'b0;
        end
        default: ;
      endcase
    end else if (granted && ab_pmem_resp) begin
      ab_read_d  = 1'b0;
      ab_write_d = 1'b0;
      if (state_q == GNT_I) begin
        pf_addr_d  = ab_addr_q + ADDR_W'(PF_STRIDE);
        pf_valid_d = 1'b1;
      end else if (state_q == GNT_P) begin
        pf_valid_d = 1'b0;
      end else begin
        pf_valid_d = pf_valid_q;
      end
    end else begin
      ab_read_d = ab_read_q;
    end
  end

  // Completion is steered to the owner in the L2 response cycle; prefetch data is dropped.
  always_comb begin
    i_pmem_resp = 1'b0;
    d_pmem_resp = 1'b0;
    if (!reset && ab_pmem_resp) begin
      i_pmem_resp = (state_q == GNT_I);
      d_pmem_resp = (state_q == GNT_D);
    end else begin
      i_pmem_resp = 1'b0;
      d_pmem_resp = 1'b0;
    end
    i_pmem_rdata = i_pmem_resp ? ab_pmem_rdata : '0;
    d_pmem_rdata = d_pmem_resp ? ab_pmem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      pf_valid_q   <= 1'b0;
      pf_addr_q    <= '0;
      ab_read_q    <= 1'b0;
      ab_write_q   <= 1'b0;
      ab_addr_q    <= '0;
      ab_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      pf_valid_q   <= pf_valid_d;
      pf_addr_q    <= pf_addr_d;
      ab_read_q    <= ab_read_d;
      ab_write_q   <= ab_write_d;
      ab_addr_q    <= ab_addr_d;
      ab_wdata_q   <= ab_wdata_d;
    end
  end

  assign ab_pmem_read    = ab_read_q;
  assign ab_pmem_write   = ab_write_q;
  assign ab_pmem_address = ab_addr_q;
  assign ab_pmem_wdata   = ab_wdata_q;

endmodule
